// File: rtl/echo_pkg.sv
// Shared definitions for the echo delay-line controller.
//   state_e    : controller sequencing states
//   FEEDBACK_W : width of the unsigned feedback gain (value/256)
package echo_pkg;

  localparam int FEEDBACK_W = 8;

  typedef enum logic [2:0] {
    CLEAR = 3'd0,
    IDLE  = 3'd1,
    READ  = 3'd2,
    WAIT  = 3'd3,
    WRITE = 3'd4
  } state_e;

endpackage

// File: rtl/echo_feedback_sat.sv
// Combinational scale-add-saturate for the echo feedback path:
//   result = sat(in_sample + ((delayed * feedback) >>> 8))
// Ports:
//   in_sample : new input sample (signed)
//   delayed   : sample read back from the delay line (signed)
//   feedback  : unsigned gain, value/256
//   result    : sum clamped to the signed range of width bits
module echo_feedback_sat
  import echo_pkg::*;
#(
  parameter int width = 16
) (
  input  logic signed [width-1:0]      in_sample,
  input  logic signed [width-1:0]      delayed,
  input  logic        [FEEDBACK_W-1:0] feedback,
  output logic signed [width-1:0]      result
);

  localparam logic signed [width+8:0] MAX_W = {10'b0, {(width-1){1'b1}}};
  localparam logic signed [width+8:0] MIN_W = {{10{1'b1}}, {(width-1){1'b0}}};

  logic signed [width+8:0] delayed_x;
  logic signed [width+8:0] gain_x;
  logic signed [width+8:0] in_x;
  logic signed [width+8:0] product;
  logic signed [width+8:0] sum_w;

  always_comb begin
    delayed_x = {{9{delayed[width-1]}}, delayed};
    // Gain is zero-extended so it is always non-negative.
    gain_x    = {{(width+1){1'b0}}, feedback};
    in_x      = {{9{in_sample[width-1]}}, in_sample};
    product   = delayed_x * gain_x;
    sum_w     = (product >>> 8) + in_x;
    if (sum_w > MAX_W) begin
      result = MAX_W[width-1:0];
    end else if (sum_w < MIN_W) begin
      result = MIN_W[width-1:0];
    end else begin
      result = sum_w[width-1:0];
    end
  end

endmodule

// File: rtl/echo_delay_controller.sv
// Echo delay-line sequencer. Clears the external single-port RAM after
// reset, then per accepted sample reads the word delay_len+1 samples old,
// emits it as the wet output and writes back input + scaled feedback.
// Ports:
//   clk, reset_n            : clock, async active-low reset
//   in_valid/in_ready/in_data : input sample handshake
//   delay_len, feedback     : delay (delay_len+1 samples) and gain, latched per sample
//   out_valid/out_data      : one-cycle pulse with the delayed sample
//   ram_addr/ram_write_en/ram_write_data/ram_read_data : RAM port
module echo_delay_controller
  import echo_pkg::*;
#(
  parameter  int width = 16,
  parameter  int size  = 256,
  localparam int aw    = $clog2(size)
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [width-1:0]      in_data,
  input  logic [aw-1:0]         delay_len,
  input  logic [FEEDBACK_W-1:0] feedback,
  output logic                  out_valid,
  output logic [width-1:0]      out_data,
  output logic [aw-1:0]         ram_addr,
  output logic                  ram_write_en,
  output logic [width-1:0]      ram_write_data,
  input  logic [width-1:0]      ram_read_data
);

  state_e                state_q, state_d;
  logic [aw-1:0]         ptr_q, ptr_d;
  logic [aw-1:0]         clear_addr_q, clear_addr_d;
  logic [aw-1:0]         delay_len_q, delay_len_d;
  logic [FEEDBACK_W-1:0] feedback_q, feedback_d;
  logic [width-1:0]      in_data_q, in_data_d;
  logic [width-1:0]      delayed_q, delayed_d;
  logic [width-1:0]      wdata_q, wdata_d;
  logic [width-1:0]      out_data_q, out_data_d;
  logic                  in_ready_q, in_ready_d;
  logic                  out_valid_q, out_valid_d;
  logic [width-1:0]      sat_result;

  echo_feedback_sat #(
    .width(width)
  ) u_feedback_sat (
    .in_sample(in_data_q),
    .delayed  (ram_read_data),
    .feedback (feedback_q),
    .result   (sat_result)
  );

  always_comb begin
    state_d      = state_q;
    ptr_d        = ptr_q;
    clear_addr_d = clear_addr_q;
    delay_len_d  = delay_len_q;
    feedback_d   = feedback_q;
    in_data_d    = in_data_q;
    delayed_d    = delayed_q;
    wdata_d      = wdata_q;
    out_data_d   = out_data_q;
    in_ready_d   = in_ready_q;
    out_valid_d  = 1'b0;
    case (state_q)
      CLEAR: begin
        // size is a power of two, so the counter wraps back to 0 on exit.
        clear_addr_d = clear_addr_q + aw'(1);
        if (clear_addr_q == '1) begin
          state_d    = IDLE;
          in_ready_d = 1'b1;
        end
      end
      IDLE: begin
        if (in_valid && in_ready_q) begin
          in_data_d   = in_data;
          feedback_d  = feedback;
          delay_len_d = delay_len;
          in_ready_d  = 1'b0;
          state_d     = READ;
        end
      end
      READ: begin
        state_d = WAIT;
      end
      WAIT: begin
        delayed_d = ram_read_data;
        wdata_d   = sat_result;
        state_d   = WRITE;
      end
      WRITE: begin
        out_data_d  = delayed_q;
        out_valid_d = 1'b1;
        // >= rather than == so a shortened delay still wraps a pointer
        // that already sits beyond the new length.
        ptr_d       = (ptr_q >= delay_len_q) ? '0 : ptr_q + aw'(1);
        in_ready_d  = 1'b1;
        state_d     = IDLE;
      end
      default: begin
        state_d = CLEAR;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= CLEAR;
      ptr_q        <= '0;
      clear_addr_q <= '0;
      delay_len_q  <= '0;
      feedback_q   <= '0;
      in_data_q    <= '0;
      delayed_q    <= '0;
      wdata_q      <= '0;
      out_data_q   <= '0;
      in_ready_q   <= 1'b0;
      out_valid_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      ptr_q        <= ptr_d;
      clear_addr_q <= clear_addr_d;
      delay_len_q  <= delay_len_d;
      feedback_q   <= feedback_d;
      in_data_q    <= in_data_d;
      delayed_q    <= delayed_d;
      wdata_q      <= wdata_d;
      out_data_q   <= out_data_d;
      in_ready_q   <= in_ready_d;
      out_valid_q  <= out_valid_d;
    end
  end

  assign in_ready       = in_ready_q;
  assign out_valid      = out_valid_q;
  assign out_data       = out_data_q;
  assign ram_write_en   = (state_q == CLEAR) || (state_q == WRITE);
  assign ram_addr       = (state_q == CLEAR) ? clear_addr_q : ptr_q;
  assign ram_write_data = (state_q == WRITE) ? wdata_q : '0;

endmodule

// File: tb/tb_echo_delay_controller.sv
// Self-checking bench for echo_delay_controller: directed table vectors,
// hand-written reset/clear sequences and randomized samples checked
// against a per-sample delay-line model.
module tb_echo_delay_controller;

  localparam int W    = 16;
  localparam int SIZE = 256;
  localparam int AW   = 8;
  localparam int MAXV = (1 << (W - 1)) - 1;
  localparam int MINV = -(1 << (W - 1));

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [W-1:0]  in_data = '0;
  logic [AW-1:0] delay_len = '0;
  logic [7:0]    feedback = '0;
  logic          out_valid;
  logic [W-1:0]  out_data;
  logic [AW-1:0] ram_addr;
  logic          ram_write_en;
  logic [W-1:0]  ram_write_data;
  logic [W-1:0]  ram_read_data;

  logic [W-1:0]  ram [SIZE];

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int last_acc = 0;
  bit last_hold = 1'b0;

  int model_mem [SIZE];
  int model_ptr = 0;

  echo_delay_controller #(
    .width(W),
    .size (SIZE)
  ) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .in_data       (in_data),
    .delay_len     (delay_len),
    .feedback      (feedback),
    .out_valid     (out_valid),
    .out_data      (out_data),
    .ram_addr      (ram_addr),
    .ram_write_en  (ram_write_en),
    .ram_write_data(ram_write_data),
    .ram_read_data (ram_read_data)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Single-port RAM, registered read, write has priority.
  always @(posedge clk) begin
    if (ram_write_en) ram[ram_addr] <= ram_write_data;
    ram_read_data <= ram_write_en ? ram_write_data : ram[ram_addr];
  end

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic void model_reset();
    foreach (model_mem[i]) model_mem[i] = 0;
    model_ptr = 0;
  endfunction

  // One sample through an ideal delay line: read the oldest word, write back
  // x + floor(d*fb/256) clamped, advance the pointer modulo (dl+1).
  function automatic void model_step(input int x, input int fb, input int dl,
                                     output int e_ptr, output int e_w, output int e_out);
    int d, p, q, s;
    d = model_mem[model_ptr];
    p = d * fb;
    q = p / 256;
    if (p < 0 && (p % 256) != 0) q = q - 1;
    s = x + q;
    if (s > MAXV) s = MAXV;
    if (s < MINV) s = MINV;
    e_ptr = model_ptr;
    e_w   = s;
    e_out = d;
    model_mem[model_ptr] = s;
    model_ptr = (model_ptr >= dl) ? 0 : model_ptr + 1;
  endfunction

  // Expects to be called at a negedge; returns at the negedge of the cycle
  // in which out_valid is high (the IDLE cycle following WRITE).
  task automatic send(input int x, input int fb, input int dl, input bit hold,
                      input int e_ptr, input int e_w, input int e_out);
    int n;
    int acc;
    n = 0;
    in_valid  = 1'b1;
    in_data   = x[W-1:0];
    feedback  = fb[7:0];
    delay_len = dl[AW-1:0];
    while (!in_ready && n < 600) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      check("ready_timeout", 0, 1);
      in_valid = 1'b0;
      return;
    end
    @(posedge clk);
    #1;
    acc = cyc;
    if (last_hold) check("accept_spacing", acc - last_acc, 4);
    last_acc  = acc;
    last_hold = hold;
    @(negedge clk);
    if (!hold) in_valid = 1'b0;
    check("read_addr", ram_addr, e_ptr);
    check("read_we", ram_write_en, 0);
    check("read_ready", in_ready, 0);
    check("read_out_valid", out_valid, 0);
    @(negedge clk);
    check("wait_out_valid", out_valid, 0);
    check("wait_we", ram_write_en, 0);
    @(negedge clk);
    check("write_we", ram_write_en, 1);
    check("write_addr", ram_addr, e_ptr);
    check("write_data", $signed(ram_write_data), e_w);
    check("write_out_valid", out_valid, 0);
    @(negedge clk);
    check("out_valid", out_valid, 1);
    check("out_data", $signed(out_data), e_out);
    check("ready_after", in_ready, 1);
  endtask

  // Called at the negedge where reset_n was just released.
  task automatic sweep_check();
    for (int i = 0; i < SIZE; i++) begin
      check("clear_addr", ram_addr, i);
      check("clear_ctl", {ram_write_en, ram_write_data == '0, in_ready, out_valid}, 4'b1100);
      @(negedge clk);
    end
    check("ready_after_clear", in_ready, 1);
    check("we_after_clear", ram_write_en, 0);
  endtask

  task automatic apply_reset();
    reset_n  = 1'b0;
    in_valid = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_ready", in_ready, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_data", out_data, 0);
    check("rst_we", ram_write_en, 1);
    check("rst_addr", ram_addr, 0);
    check("rst_wdata", ram_write_data, 0);
    model_reset();
    last_hold = 1'b0;
    reset_n = 1'b1;
    sweep_check();
  endtask

  typedef struct {
    bit rst;
    int x;
    int fb;
    int dl;
    bit hold;
    int e_ptr;
    int e_w;
    int e_out;
  } vec_t;

  vec_t tbl[$];

  function automatic void add(input bit rst, input int x, input int fb, input int dl,
                              input bit hold, input int e_ptr, input int e_w, input int e_out);
    vec_t v;
    v.rst = rst; v.x = x; v.fb = fb; v.dl = dl; v.hold = hold;
    v.e_ptr = e_ptr; v.e_w = e_w; v.e_out = e_out;
    tbl.push_back(v);
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int ep, ew, eo;
    int x, fb, dl;
    bit hold;

    // delay_len=3, no feedback: plain 4-sample delay, pointer 0,1,2,3,0...
    add(1, 1, 0, 3, 0, 0, 1, 0);
    add(0, 2, 0, 3, 0, 1, 2, 0);
    add(0, 3, 0, 3, 0, 2, 3, 0);
    add(0, 4, 0, 3, 0, 3, 4, 0);
    add(0, 5, 0, 3, 0, 0, 5, 1);
    add(0, 6, 0, 3, 0, 1, 6, 2);
    add(0, 7, 0, 3, 0, 2, 7, 3);
    add(0, 8, 0, 3, 0, 3, 8, 4);
    // delay_len=0, half feedback
    add(1, 1000, 128, 0, 0, 0, 1000, 0);
    add(0, 1000, 128, 0, 0, 0, 1500, 1000);
    add(0, 1000, 128, 0, 0, 0, 1750, 1500);
    add(0, 1000, 128, 0, 0, 0, 1875, 1750);
    // positive saturation
    add(1, 32767, 255, 0, 0, 0, 32767, 0);
    add(0, 32767, 255, 0, 0, 0, 32767, 32767);
    add(0, 32767, 255, 0, 0, 0, 32767, 32767);
    // negative saturation
    add(1, -32768, 255, 0, 0, 0, -32768, 0);
    add(0, -32768, 255, 0, 0, 0, -32768, -32768);
    add(0, -32768, 255, 0, 0, 0, -32768, -32768);
    // back-to-back, delay shortened 7 -> 2 with the pointer at 5
    add(1, 10, 0, 7, 1, 0, 10, 0);
    add(0, 20, 0, 7, 1, 1, 20, 0);
    add(0, 30, 0, 7, 1, 2, 30, 0);
    add(0, 40, 0, 7, 1, 3, 40, 0);
    add(0, 50, 0, 7, 1, 4, 50, 0);
    add(0, 60, 0, 2, 1, 5, 60, 0);
    add(0, 70, 0, 2, 1, 0, 70, 10);
    add(0, 80, 0, 2, 1, 1, 80, 20);
    add(0, 90, 0, 2, 1, 2, 90, 30);
    add(0, 100, 0, 2, 0, 0, 100, 70);

    @(negedge clk);
    foreach (tbl[i]) begin
      if (tbl[i].rst) apply_reset();
      model_step(tbl[i].x, tbl[i].fb, tbl[i].dl, ep, ew, eo);
      send(tbl[i].x, tbl[i].fb, tbl[i].dl, tbl[i].hold, tbl[i].e_ptr, tbl[i].e_w, tbl[i].e_out);
    end

    // Reset asserted while a transaction sits in WAIT.
    apply_reset();
    for (int i = 0; i < 3; i++) begin
      model_step(100 + i, 64, 7, ep, ew, eo);
      send(100 + i, 64, 7, 0, ep, ew, eo);
    end
    in_valid  = 1'b1;
    in_data   = 16'd500;
    feedback  = 8'd0;
    delay_len = 8'd7;
    @(posedge clk);
    @(negedge clk);
    check("mid_read_addr", ram_addr, 3);
    @(negedge clk);
    reset_n = 1'b0;
    #1;
    check("mid_rst_out_valid", out_valid, 0);
    check("mid_rst_addr", ram_addr, 0);
    check("mid_rst_we", ram_write_en, 1);
    check("mid_rst_ready", in_ready, 0);
    in_valid = 1'b0;
    @(negedge clk);
    check("mid_rst_out_valid2", out_valid, 0);
    @(negedge clk);
    model_reset();
    last_hold = 1'b0;
    reset_n = 1'b1;
    sweep_check();
    model_step(123, 0, 7, ep, ew, eo);
    send(123, 0, 7, 0, ep, ew, eo);

    // Randomized samples against the model; in_valid raised during the clear.
    reset_n  = 1'b0;
    repeat (2) @(negedge clk);
    model_reset();
    last_hold = 1'b0;
    reset_n  = 1'b1;
    in_valid = 1'b1;
    dl = 5;
    for (int i = 0; i < 200; i++) begin
      case ($urandom_range(0, 7))
        0:       x = MAXV;
        1:       x = MINV;
        default: x = int'($urandom_range(0, 65535)) - 32768;
      endcase
      fb = ($urandom_range(0, 3) == 0) ? 255 : int'($urandom_range(0, 255));
      if ($urandom_range(0, 7) == 0)
        dl = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 255)) : int'($urandom_range(0, 7));
      hold = 1'($urandom_range(0, 1));
      model_step(x, fb, dl, ep, ew, eo);
      send(x, fb, dl, hold, ep, ew, eo);
      if (!hold) repeat ($urandom_range(0, 2)) @(negedge clk);
    end
    in_valid = 1'b0;
    repeat (4) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
